// File: rtl/div_mant_seq.sv
// Iterative restoring significand divider: one quotient bit per clock, MSB first.
// Optional macro DIV_EARLY_TERM_EN stops iterating as soon as the remainder is zero.
module div_mant_seq #(
  parameter int SW = 24,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          Sgn_X,
  input  logic          Sgn_Y,
  input  logic [SW-1:0] Sig_X,
  input  logic [SW-1:0] Sig_Y,
  output logic          ready,
  output logic          done,
  output logic          Sgn_Info,
  output logic [SW+1:0] Quot,
  output logic          Sticky,
  output logic          Div_Zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(SW + 1);

  state_t        state;
  logic [SW:0]   rem;
  logic [SW-1:0] dvs;
  logic [CW-1:0] cnt;

  logic [SW+1:0] diff;
  logic          ge;
  logic [SW:0]   rem_next;
  logic [SW+1:0] quot_next;

  // Trial subtraction; a set MSB on the (SW+2)-bit difference means rem < divisor.
  always_comb begin
    diff      = {1'b0, rem} - {2'b00, dvs};
    ge        = ~diff[SW+1];
    if (ge) begin
      rem_next = {diff[SW-1:0], 1'b0};
    end else begin
      rem_next = {rem[SW-1:0], 1'b0};
    end
    quot_next = {Quot[SW:0], ge};
  end

`ifdef DIV_EARLY_TERM_EN
  logic [CW-1:0] pad;
  logic [SW+1:0] quot_aligned;

  // Zeros still owed to the quotient when the remainder vanishes early.
  always_comb begin
    pad          = LAST_CNT - cnt;
    quot_aligned = quot_next << pad;
  end
`endif

  // Control FSM with all result outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      Sgn_Info <= 1'b0;
      Quot     <= '0;
      Sticky   <= 1'b0;
      Div_Zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvs      <= Sig_Y;
            rem      <= {1'b0, Sig_X};
            Sgn_Info <= Sgn_X ^ Sgn_Y;
            cnt      <= '0;
            ready    <= 1'b0;
            Sticky   <= 1'b0;
            if (Sig_Y == '0) begin
              Div_Zero <= 1'b1;
              Quot     <= {(SW+2){1'b1}};
              state    <= FIN;
            end else begin
              Div_Zero <= 1'b0;
              Quot     <= '0;
              state    <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem <= rem_next;
          cnt <= cnt + CW'(1);
`ifdef DIV_EARLY_TERM_EN
          if (rem_next == '0) begin
            Quot   <= quot_aligned;
            Sticky <= 1'b0;
            state  <= FIN;
          end else if (cnt == LAST_CNT) begin
            Quot   <= quot_next;
            Sticky <= 1'b1;
            state  <= FIN;
          end else begin
            Quot   <= quot_next;
            state  <= CALC;
          end
`else
          Quot <= quot_next;
          if (cnt == LAST_CNT) begin
            Sticky <= (rem_next != '0);
            state  <= FIN;
          end else begin
            state  <= CALC;
          end
`endif
        end
        FIN: begin
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_mant_seq.sv
// Self-checking bench for div_mant_seq (SW=24): directed table, corner sequences,
// and random operands against an arithmetic quotient/remainder model.
module tb_div_mant_seq;
  localparam int SW = 24;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          Sgn_X = 1'b0;
  logic          Sgn_Y = 1'b0;
  logic [SW-1:0] Sig_X = '0;
  logic [SW-1:0] Sig_Y = '0;
  logic          ready, done, Sgn_Info, Sticky, Div_Zero;
  logic [SW+1:0] Quot;

  int n_cmp = 0;
  int n_fail = 0;

  div_mant_seq #(.SW(SW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .Sgn_X(Sgn_X), .Sgn_Y(Sgn_Y),
    .Sig_X(Sig_X), .Sig_Y(Sig_Y), .ready(ready), .done(done),
    .Sgn_Info(Sgn_Info), .Quot(Quot), .Sticky(Sticky), .Div_Zero(Div_Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] x;
    logic [23:0] y;
    logic        sx;
    logic        sy;
    logic [25:0] q;
    logic        st;
    logic        sg;
    logic        dz;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Quotient of X*2^(SW+1)/Y by plain integer arithmetic.
  function automatic void model(input logic [23:0] x, input logic [23:0] y,
                                output logic [25:0] q, output logic st);
    logic [63:0] n;
    n  = {40'd0, x} << 25;
    q  = 26'(n / {40'd0, y});
    st = (n % {40'd0, y}) != 64'd0;
  endfunction

  // Edges after the start edge until done rises.
  function automatic int exp_lat(input logic [23:0] x, input logic [23:0] y);
    if (y == 24'd0) return 1;
`ifdef DIV_EARLY_TERM_EN
    for (int k = 1; k <= SW + 2; k++) begin
      if ((({40'd0, x} << (k - 1)) % {40'd0, y}) == 64'd0) return k + 1;
    end
`endif
    return SW + 3;
  endfunction

  // Issue one operation; optionally pulse start again with other operands at edge inj.
  task automatic do_op(input logic [23:0] x, input logic [23:0] y, input logic sx,
                       input logic sy, input int inj, output int lat);
    @(negedge clk);
    Sig_X = x; Sig_Y = y; Sgn_X = sx; Sgn_Y = sy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_low_after_start", {63'd0, ready}, 64'd0);
    lat = -1;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
      if (i == inj) begin
        start = 1'b1; Sig_X = 24'hFFFFFF; Sig_Y = 24'h812345; Sgn_X = 1'b1; Sgn_Y = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end else begin
      chk("ready_with_done", {63'd0, ready}, 64'd1);
      @(posedge clk); #1;
      chk("done_one_cycle", {63'd0, done}, 64'd0);
    end
  endtask

  task automatic check_results(input string tag, input logic [25:0] q, input logic st,
                               input logic sg, input logic dz);
    chk({tag, "_quot"}, {38'd0, Quot}, {38'd0, q});
    chk({tag, "_sticky"}, {63'd0, Sticky}, {63'd0, st});
    chk({tag, "_sign"}, {63'd0, Sgn_Info}, {63'd0, sg});
    chk({tag, "_divzero"}, {63'd0, Div_Zero}, {63'd0, dz});
  endtask

  initial begin
    vec_t tbl[6];
    int lat;
    int dcount;
    logic [23:0] rx, ry;
    logic rsx, rsy, mst;
    logic [25:0] mq;

    tbl[0] = '{24'h800000, 24'h800000, 1'b0, 1'b0, 26'h2000000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{24'hC00000, 24'h800000, 1'b1, 1'b0, 26'h3000000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{24'h800000, 24'hC00000, 1'b1, 1'b1, 26'h1555555, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{24'hA00000, 24'h000000, 1'b0, 1'b1, 26'h3FFFFFF, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{24'h800000, 24'h800000, 1'b0, 1'b0, 26'h2000000, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{24'h000000, 24'h9ABCDE, 1'b1, 1'b0, 26'h0000000, 1'b0, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_ready", {63'd0, ready}, 64'd1);
    chk("reset_done", {63'd0, done}, 64'd0);
    check_results("reset", 26'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].x, tbl[i].y, tbl[i].sx, tbl[i].sy, 0, lat);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(exp_lat(tbl[i].x, tbl[i].y)));
      check_results($sformatf("tbl%0d", i), tbl[i].q, tbl[i].st, tbl[i].sg, tbl[i].dz);
    end

    // Second start 5 cycles into an operation must be ignored.
    do_op(24'h800000, 24'hC00000, 1'b1, 1'b1, 5, lat);
    chk("ignored_start_latency", 64'(lat), 64'(SW + 3));
    check_results("ignored_start", 26'h1555555, 1'b1, 1'b0, 1'b0);

    // Reset 10 cycles into an operation aborts it with no done.
    @(negedge clk);
    Sig_X = 24'h800000; Sig_Y = 24'hC00000; Sgn_X = 1'b1; Sgn_Y = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_ready", {63'd0, ready}, 64'd1);
    chk("abort_done", {63'd0, done}, 64'd0);
    check_results("abort", 26'd0, 1'b0, 1'b0, 1'b0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    do_op(24'hC00000, 24'h800000, 1'b1, 1'b0, 0, lat);
    chk("after_abort_latency", 64'(lat), 64'(exp_lat(24'hC00000, 24'h800000)));
    check_results("after_abort", 26'h3000000, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rx  = {1'b1, 23'($urandom)};
      ry  = {1'b1, 23'($urandom)};
      if (i % 8 == 3) ry = rx;
      if (i % 8 == 5) ry = 24'h800000;
      if (i % 8 == 6) rx = {rx[23:8], 8'd0};
      rsx = 1'($urandom);
      rsy = 1'($urandom);
      model(rx, ry, mq, mst);
      do_op(rx, ry, rsx, rsy, 0, lat);
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat(rx, ry)));
      check_results($sformatf("rnd%0d", i), mq, mst, rsx ^ rsy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
